// File: rtl/fc_argmax_select.sv
// fc_argmax_select: top-1/top-2 tracker over N_CLASSES serial class scores.
// In: clk, rst, start, score_valid/score_in. Out: score_ready, busy, done, class_idx, max_score, margin.
module fc_argmax_select #(
  parameter int N_CLASSES = 10,
  parameter int SCORE_W   = 46,
  parameter int IDX_W     = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      score_valid,
  input  logic signed [SCORE_W-1:0] score_in,
  output logic                      score_ready,
  output logic                      busy,
  output logic                      done,
  output logic [IDX_W-1:0]          class_idx,
  output logic signed [SCORE_W-1:0] max_score,
  output logic [SCORE_W:0]          margin
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  localparam logic signed [SCORE_W-1:0] S_MIN =
    {1'b1, {(SCORE_W-1){1'b0}}};
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(N_CLASSES - 1);

  state_t state, state_nx;

  logic [IDX_W-1:0]          count;
  logic [IDX_W-1:0]          best_idx;
  logic [IDX_W-1:0]          idx_nx;
  logic signed [SCORE_W-1:0] best;
  logic signed [SCORE_W-1:0] second;
  logic signed [SCORE_W-1:0] best_nx;
  logic signed [SCORE_W-1:0] second_nx;
  logic [SCORE_W:0]          margin_nx;
  logic                      accept;
  logic                      last;

  assign accept = score_valid && score_ready;
  assign last   = accept && (count == LAST_IDX);

  always_comb begin
    state_nx    = state;
    score_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = COLLECT;
      end
      COLLECT: begin
        score_ready = 1'b1;
        busy        = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Strict greater-than keeps the lowest index on ties;
  // an equal score lands in second, giving margin 0.
  always_comb begin
    best_nx   = best;
    second_nx = second;
    idx_nx    = best_idx;
    if (accept) begin
      if (score_in > best) begin
        second_nx = best;
        best_nx   = score_in;
        idx_nx    = count;
      end else if (score_in > second) begin
        second_nx = score_in;
      end
    end
    // One extra bit after sign extension: best >= second,
    // so the difference is non-negative and cannot overflow.
    margin_nx = {best_nx[SCORE_W-1], best_nx}
              - {second_nx[SCORE_W-1], second_nx};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      best      <= S_MIN;
      second    <= S_MIN;
      best_idx  <= '0;
      class_idx <= '0;
      max_score <= '0;
      margin    <= '0;
    end else begin
      if (state == IDLE && start) begin
        count    <= '0;
        best     <= S_MIN;
        second   <= S_MIN;
        best_idx <= '0;
      end else if (accept) begin
        count    <= count + IDX_W'(1);
        best     <= best_nx;
        second   <= second_nx;
        best_idx <= idx_nx;
      end
      if (last) begin
        class_idx <= idx_nx;
        max_score <= best_nx;
        margin    <= margin_nx;
      end
    end
  end

endmodule
